// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and FSM state types for the memory-mapped UART
package uart_pkg;

  localparam logic [3:0] OFS_TXD    = 4'h0;
  localparam logic [3:0] OFS_RXD    = 4'h4;
  localparam logic [3:0] OFS_STATUS = 4'h8;
  localparam logic [3:0] OFS_CTRL   = 4'hC;

  localparam int ST_RX_VALID = 0;
  localparam int ST_TX_FULL  = 1;
  localparam int ST_TX_EMPTY = 2;
  localparam int ST_TX_BUSY  = 3;
  localparam int ST_RX_OVR   = 4;
  localparam int ST_RX_FRM   = 5;
  localparam int ST_TX_OVF   = 6;

  localparam int DATA_BITS = 8;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - small synchronous FIFO; a push while full is dropped even if a pop happens that cycle
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign o_full  = (count_q == CNT_FULL);
  assign o_empty = (count_q == '0);
  assign do_push = i_push & ~o_full;
  assign do_pop  = i_pop & ~o_empty;
  assign o_data  = mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= i_data;
  end

endmodule

// File: rtl/uart_mmio_responder.sv
// rtl/uart_mmio_responder.sv - memory-mapped 8N1 UART with TX FIFO, RX holding register and status/ctrl registers
// Interrupt logic and the CTRL register exist only when UART_IRQ_EN is defined.
module uart_mmio_responder
  import uart_pkg::*;
#(
  parameter int          CLK_DIV   = 868,
  parameter logic [31:0] BASE_ADDR = 32'h40000018,
  parameter int          TX_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_address,
  input  logic        i_read,
  input  logic        i_write,
  input  logic [31:0] i_write_data,
  output logic [31:0] o_read_data,
  output logic        o_hit,
  input  logic        i_rx,
  output logic        o_tx,
  output logic        o_irq
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] BIT_END  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

  logic [31:0] ofs;
  logic        sel_txd, sel_rxd, sel_status, sel_ctrl;
  logic        wr_txd, rd_rxd, wr_status;

  logic        rx_valid_q, rx_ovr_q, rx_frm_q, tx_ovf_q;
  logic [7:0]  rx_byte_q;
  logic [6:0]  status;
  logic [1:0]  ctrl_rd;

  logic        fifo_pop, fifo_full, fifo_empty;
  logic [7:0]  fifo_rdata;

  tx_state_t   tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shreg_q, tx_shreg_d;
  logic        tx_q, tx_d;
  logic        tx_busy;

  rx_state_t   rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shreg_q, rx_shreg_d;
  logic        rx_meta_q, rx_sync_q, rx_prev_q;
  logic        rx_land, rx_frm_evt;

  logic        unused_wdata;
  assign unused_wdata = ^i_write_data[31:8];

  // BASE_ADDR need not be 16-byte aligned, so decode on the offset rather than masking the address.
  assign ofs        = i_address - BASE_ADDR;
  assign o_hit      = (ofs[31:4] == 28'd0) && (ofs[1:0] == 2'b00);
  assign sel_txd    = o_hit && (ofs[3:0] == OFS_TXD);
  assign sel_rxd    = o_hit && (ofs[3:0] == OFS_RXD);
  assign sel_status = o_hit && (ofs[3:0] == OFS_STATUS);
  assign sel_ctrl   = o_hit && (ofs[3:0] == OFS_CTRL);
  assign wr_txd     = i_write & sel_txd;
  assign rd_rxd     = i_read & sel_rxd;
  assign wr_status  = i_write & sel_status;

  assign tx_busy = (tx_state_q != TX_IDLE);

  always_comb begin
    status              = '0;
    status[ST_RX_VALID] = rx_valid_q;
    status[ST_TX_FULL]  = fifo_full;
    status[ST_TX_EMPTY] = fifo_empty;
    status[ST_TX_BUSY]  = tx_busy;
    status[ST_RX_OVR]   = rx_ovr_q;
    status[ST_RX_FRM]   = rx_frm_q;
    status[ST_TX_OVF]   = tx_ovf_q;
  end

  always_comb begin
    o_read_data = '0;
    if (sel_rxd)         o_read_data = {24'd0, rx_byte_q};
    else if (sel_status) o_read_data = {25'd0, status};
    else if (sel_ctrl)   o_read_data = {30'd0, ctrl_rd};
  end

  uart_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (wr_txd),
    .i_data  (i_write_data[7:0]),
    .i_pop   (fifo_pop),
    .o_data  (fifo_rdata),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  // Event sets are applied after clears so a same-cycle event always wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_valid_q <= 1'b0;
      rx_byte_q  <= '0;
      rx_ovr_q   <= 1'b0;
      rx_frm_q   <= 1'b0;
      tx_ovf_q   <= 1'b0;
    end else begin
      if (rd_rxd) rx_valid_q <= 1'b0;
      if (wr_status && i_write_data[ST_RX_OVR]) rx_ovr_q <= 1'b0;
      if (wr_status && i_write_data[ST_RX_FRM]) rx_frm_q <= 1'b0;
      if (wr_status && i_write_data[ST_TX_OVF]) tx_ovf_q <= 1'b0;
      if (rx_land) begin
        if (rx_valid_q && !rd_rxd) begin
          rx_ovr_q <= 1'b1;
        end else begin
          rx_byte_q  <= rx_shreg_q;
          rx_valid_q <= 1'b1;
        end
      end
      if (rx_frm_evt) rx_frm_q <= 1'b1;
      if (wr_txd && fifo_full) tx_ovf_q <= 1'b1;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + CNT_ONE;
    tx_bit_d   = tx_bit_q;
    tx_shreg_d = tx_shreg_q;
    tx_d       = tx_q;
    fifo_pop   = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        tx_d     = 1'b1;
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          tx_shreg_d = fifo_rdata;
          tx_state_d = TX_START;
          tx_d       = 1'b0;
        end
      end
      TX_START: begin
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = TX_DATA;
          tx_d       = tx_shreg_q[0];
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d = '0;
          if (tx_bit_q == LAST_BIT) begin
            tx_state_d = TX_STOP;
            tx_d       = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shreg_d = {1'b0, tx_shreg_q[7:1]};
            tx_d       = tx_shreg_q[1];
          end
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d = '0;
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            tx_shreg_d = fifo_rdata;
            tx_state_d = TX_START;
            tx_d       = 1'b0;
          end else begin
            tx_state_d = TX_IDLE;
            tx_d       = 1'b1;
          end
        end
      end
      default: begin
        tx_state_d = TX_IDLE;
        tx_d       = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shreg_q <= '0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shreg_q <= tx_shreg_d;
      tx_q       <= tx_d;
    end
  end

  assign o_tx = tx_q;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + CNT_ONE;
    rx_bit_d   = rx_bit_q;
    rx_shreg_d = rx_shreg_q;
    rx_land    = 1'b0;
    rx_frm_evt = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_sync_q) rx_state_d = RX_START;
      end
      RX_START: begin
        // Mid-start check rejects glitches shorter than half a bit.
        if (rx_cnt_q == HALF_END) begin
          rx_cnt_d = '0;
          if (rx_sync_q) begin
            rx_state_d = RX_IDLE;
          end else begin
            rx_state_d = RX_DATA;
            rx_bit_d   = '0;
          end
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_END) begin
          rx_cnt_d   = '0;
          rx_shreg_d = {rx_sync_q, rx_shreg_q[7:1]};
          if (rx_bit_q == LAST_BIT) rx_state_d = RX_STOP;
          else                      rx_bit_d   = rx_bit_q + 3'd1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_END) begin
          rx_state_d = RX_IDLE;
          rx_land    = rx_sync_q;
          rx_frm_evt = ~rx_sync_q;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shreg_q <= '0;
    end else begin
      rx_meta_q  <= i_rx;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shreg_q <= rx_shreg_d;
    end
  end

`ifdef UART_IRQ_EN
  logic [1:0] ctrl_q;
  logic       irq_q;
  logic       wr_ctrl;

  assign wr_ctrl = i_write & sel_ctrl;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      if (wr_ctrl) ctrl_q <= i_write_data[1:0];
      irq_q <= (ctrl_q[0] & rx_valid_q) | (ctrl_q[1] & fifo_empty & ~tx_busy);
    end
  end

  assign ctrl_rd = ctrl_q;
  assign o_irq   = irq_q;
`else
  assign ctrl_rd = 2'b00;
  assign o_irq   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_mmio_responder.sv
// tb/tb_uart_mmio_responder.sv - directed self-checking bench for uart_mmio_responder at CLK_DIV=16
`timescale 1ns/1ps
module tb_uart_mmio_responder;

  localparam int DIV = 16;
  localparam logic [31:0] A_TXD  = 32'h40000018;
  localparam logic [31:0] A_RXD  = 32'h4000001C;
  localparam logic [31:0] A_ST   = 32'h40000020;
  localparam logic [31:0] A_CTRL = 32'h40000024;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] i_address = '0;
  logic        i_read = 1'b0;
  logic        i_write = 1'b0;
  logic [31:0] i_write_data = '0;
  logic [31:0] o_read_data;
  logic        o_hit;
  logic        i_rx = 1'b1;
  logic        o_tx;
  logic        o_irq;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] mon_q[$];
  longint     mon_t[$];

  always #5 clk = ~clk;

  uart_mmio_responder #(.CLK_DIV(DIV), .BASE_ADDR(32'h40000018), .TX_DEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_address    (i_address),
    .i_read       (i_read),
    .i_write      (i_write),
    .i_write_data (i_write_data),
    .o_read_data  (o_read_data),
    .o_hit        (o_hit),
    .i_rx         (i_rx),
    .o_tx         (o_tx),
    .o_irq        (o_irq)
  );

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    i_address = a; i_write_data = d; i_write = 1'b1;
    @(posedge clk); #1;
    i_write = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic h);
    @(negedge clk);
    i_address = a; i_read = 1'b1;
    #1; d = o_read_data; h = o_hit;
    @(posedge clk); #1;
    i_read = 1'b0;
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop);
    @(negedge clk); i_rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      i_rx = b[i];
      repeat (DIV) @(negedge clk);
    end
    i_rx = stop;
    repeat (DIV) @(negedge clk);
    i_rx = 1'b1;
  endtask

  // Serial-line decoder: samples mid-bit and records each byte with its start-edge time.
  initial begin
    logic [7:0] b;
    longint t;
    forever begin
      @(negedge o_tx);
      t = $time;
      repeat (DIV/2) @(posedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (DIV) @(posedge clk); #1;
        b[i] = o_tx;
      end
      repeat (DIV) @(posedge clk);
      mon_q.push_back(b);
      mon_t.push_back(t);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic        h;
    logic [7:0]  eb;
    logic [7:0]  exp2 [5];
    int          k;

    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;

    // Reset state
    expect_eq("rst_tx", o_tx, 1);
    expect_eq("rst_irq", o_irq, 0);
    bus_read(A_ST, d, h);   expect_eq("rst_status", d, 32'h04); expect_eq("rst_hit", h, 1);
    bus_read(A_RXD, d, h);  expect_eq("rst_rxd", d, 0);
    bus_read(A_CTRL, d, h); expect_eq("rst_ctrl", d, 0);

    // 1: single byte 0xA5
    eb = 8'hA5;
    bus_write(A_TXD, 32'h000000A5);
    for (k = 0; k < 4; k++) begin
      if (o_tx == 1'b0) break;
      @(posedge clk); #1;
    end
    expect_eq("t1_fall_latency", (k <= 2), 1);
    repeat (DIV-1) @(posedge clk); #1;
    expect_eq("t1_start_len", o_tx, 0);
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      expect_eq($sformatf("t1_bit%0d", i), o_tx, (i == 8) ? 1'b1 : eb[i]);
      repeat (DIV-1) @(posedge clk);
    end
    repeat (20) @(posedge clk);
    bus_read(A_ST, d, h); expect_eq("t1_status_idle", d, 32'h04);
    for (int j = 0; j < 400 && mon_q.size() < 1; j++) @(posedge clk);
    expect_eq("t1_mon_count", mon_q.size(), 1);
    if (mon_q.size() > 0) expect_eq("t1_mon_byte", mon_q[0], 8'hA5);
    mon_q.delete(); mon_t.delete();

    // 2: FIFO overflow while busy, contiguous frames, W1C
    exp2 = '{8'h01, 8'h10, 8'h20, 8'h30, 8'h40};
    bus_write(A_TXD, 32'h01);
    repeat (2) @(posedge clk);
    for (int i = 1; i <= 5; i++) bus_write(A_TXD, 32'(i * 16));
    bus_read(A_ST, d, h); expect_eq("t2_status_ovf", d, 32'h4A);
    bus_write(A_ST, 32'h40);
    bus_read(A_ST, d, h); expect_eq("t2_status_w1c", d, 32'h0A);
    for (int j = 0; j < 2000 && mon_q.size() < 5; j++) @(posedge clk);
    expect_eq("t2_mon_count", mon_q.size(), 5);
    if (mon_q.size() == 5) begin
      for (int i = 0; i < 5; i++) expect_eq($sformatf("t2_byte%0d", i), mon_q[i], exp2[i]);
      for (int i = 0; i < 4; i++)
        expect_eq($sformatf("t2_gap%0d", i), 32'(mon_t[i+1] - mon_t[i]), 32'(DIV * 10 * 10));
    end
    repeat (20) @(posedge clk);
    bus_read(A_ST, d, h); expect_eq("t2_status_done", d, 32'h04);

    // 3: receive 0x3C
    rx_frame(8'h3C, 1'b1);
    bus_read(A_ST, d, h);  expect_eq("t3_status_valid", d, 32'h05);
    bus_read(A_RXD, d, h); expect_eq("t3_rxd", d, 32'h3C);
    bus_read(A_ST, d, h);  expect_eq("t3_status_clr", d, 32'h04);

    // 4: overrun, then glitch rejection
    rx_frame(8'h11, 1'b1);
    rx_frame(8'h22, 1'b1);
    bus_read(A_ST, d, h);  expect_eq("t4_status_ovr", d, 32'h15);
    bus_read(A_RXD, d, h); expect_eq("t4_rxd_old", d, 32'h11);
    bus_read(A_ST, d, h);  expect_eq("t4_status_rd", d, 32'h14);
    bus_write(A_ST, 32'h10);
    bus_read(A_ST, d, h);  expect_eq("t4_status_w1c", d, 32'h04);
    @(negedge clk); i_rx = 1'b0;
    repeat (6) @(negedge clk); i_rx = 1'b1;
    repeat (40) @(negedge clk);
    bus_read(A_ST, d, h);  expect_eq("t4_glitch", d, 32'h04);

    // 5: framing error, then reset mid-TX
    rx_frame(8'h7E, 1'b0);
    bus_read(A_ST, d, h);  expect_eq("t5_status_frm", d, 32'h24);
    bus_read(A_RXD, d, h); expect_eq("t5_rxd_kept", d, 32'h11);
    bus_write(A_ST, 32'h20);
    bus_read(A_ST, d, h);  expect_eq("t5_status_w1c", d, 32'h04);
    bus_write(A_TXD, 32'h99);
    repeat (5) @(posedge clk); #1;
    expect_eq("t5_tx_low", o_tx, 0);
    #2 reset = 1'b1;
    #1 expect_eq("t5_reset_tx", o_tx, 1);
    @(negedge clk); reset = 1'b0;
    bus_read(A_ST, d, h);  expect_eq("t5_status_reset", d, 32'h04);
    expect_eq("t5_irq_reset", o_irq, 0);

    // 6: decode boundaries and interrupt
    bus_read(32'h40000030, d, h); expect_eq("t6_unmap_hit", h, 0); expect_eq("t6_unmap_data", d, 0);
    bus_read(32'h4000001A, d, h); expect_eq("t6_misalign_hit", h, 0);
    bus_read(32'h40000014, d, h); expect_eq("t6_below_hit", h, 0);
    bus_read(A_TXD, d, h);        expect_eq("t6_txd_hit", h, 1); expect_eq("t6_txd_data", d, 0);
`ifdef UART_IRQ_EN
    bus_write(A_CTRL, 32'h1);
    bus_read(A_CTRL, d, h); expect_eq("t6_ctrl", d, 32'h1);
    expect_eq("t6_irq_idle", o_irq, 0);
    fork
      rx_frame(8'h55, 1'b1);
      begin
        @(negedge clk); i_address = A_ST;
        for (k = 0; k < 400; k++) begin
          @(negedge clk);
          if (o_read_data[0]) break;
        end
        expect_eq("t6_valid_seen", (k < 400), 1);
        expect_eq("t6_irq_lag", o_irq, 0);
        @(negedge clk);
        expect_eq("t6_irq_set", o_irq, 1);
      end
    join
    bus_read(A_RXD, d, h); expect_eq("t6_rxd", d, 32'h55);
    @(posedge clk); #1;
    expect_eq("t6_irq_clr", o_irq, 0);
`else
    bus_write(A_CTRL, 32'h3);
    bus_read(A_CTRL, d, h); expect_eq("t6_ctrl_ro", d, 0);
    repeat (3) @(posedge clk); #1;
    expect_eq("t6_irq_tied", o_irq, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
